seg7_scan_decoder: RTL and testbench

- Receiving end of the multiplexed 4-digit 7-segment interface (SEG/AN) driven by the counter/display blocks.
- Samples SEG and AN, waits for a stable digit slot, then decodes each lit digit back to a 4-bit hex value.
- Reports a complete frame once every digit has been captured, and flags illegal patterns.
- Used as a self-checking monitor in benches and as an on-board loopback checker.

---
 rtl/seg7_scan_decoder.sv | 218 +++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Receiving end of a multiplexed N_DIG-digit 7-segment scan (SEG/AN).
// Registers the pins and waits until {SEG,AN} has held still for SETTLE
// cycles. It then decodes the lit digit back to a hex nibble, once per
// digit slot. frame_done pulses after every digit has been captured, and
// err pulses on an illegal segment pattern or an illegal anode code.
// Optional feature: define SEG7_DP_EN to add the decimal-point input DP and
// the dp_flags output, which is captured alongside digits.
module seg7_scan_decoder #(
    parameter int N_DIG       = 4,
    parameter int SETTLE      = 3,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           SEG,
    input  logic [N_DIG-1:0]     AN,
`ifdef SEG7_DP_EN
    input  logic                 DP,
    output logic [N_DIG-1:0]     dp_flags,
`endif
    output logic [4*N_DIG-1:0]   digits,
    output logic [N_DIG-1:0]     digit_valid,
    output logic                 frame_done,
    output logic                 err
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [1:0] {
        WAIT,
        STABLE,
        HOLD
    } state_t;

    state_t             state;
    logic [6:0]         seg_hi;
    logic [6:0]         seg_q;
    logic [N_DIG-1:0]   an_q;
    logic [3:0]         cnt;
    logic               in_change;
    logic               settled;
    logic               an_blank;
    logic               an_legal;
    logic [4:0]         dec;
    logic               seg_legal;
    logic [3:0]         seg_val;
    logic               slot_take;
    logic               flag_err;
    logic [N_DIG-1:0]   cap_bits;
    logic [N_DIG-1:0]   mask;
    logic               mask_full;

    // Map an active-high gfedcba pattern to {legal, hex value}.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b0111111: r = {1'b1, 4'h0};
            7'b0000110: r = {1'b1, 4'h1};
            7'b1011011: r = {1'b1, 4'h2};
            7'b1001111: r = {1'b1, 4'h3};
            7'b1100110: r = {1'b1, 4'h4};
            7'b1101101: r = {1'b1, 4'h5};
            7'b1111101: r = {1'b1, 4'h6};
            7'b0000111: r = {1'b1, 4'h7};
            7'b1111111: r = {1'b1, 4'h8};
            7'b1101111: r = {1'b1, 4'h9};
            7'b1110111: r = {1'b1, 4'hA};
            7'b1111100: r = {1'b1, 4'hB};
            7'b0111001: r = {1'b1, 4'hC};
            7'b1011110: r = {1'b1, 4'hD};
            7'b1111001: r = {1'b1, 4'hE};
            7'b1110001: r = {1'b1, 4'hF};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    // Work on active-high segments internally, whatever the pin polarity.
    assign seg_hi = SEG_ACT_LOW ? ~SEG : SEG;

`ifdef SEG7_DP_EN
    logic dp_hi;
    logic dp_q;
    assign dp_hi = SEG_ACT_LOW ? ~DP : DP;
`endif

    assign settled   = (cnt == SETTLE_CNT);
    assign an_blank  = &an_q;
    assign an_legal  = $onehot(~an_q);
    assign dec       = decode_seg(seg_q);
    assign seg_legal = dec[4];
    assign seg_val   = dec[3:0];
    assign mask_full = &mask;

    // Detect that the registered inputs are about to take a new value.
    always_comb begin
        // NOTE: in_change is assigned unconditionally first, so no path leaves it unassigned and no latch is inferred.
        in_change = (seg_hi != seg_q) || (AN != an_q);
`ifdef SEG7_DP_EN
        in_change = in_change || (dp_hi != dp_q);
`endif
    end

    // Decide what a freshly settled slot produces: a capture or an error.
    always_comb begin
        slot_take = 1'b0;
        flag_err  = 1'b0;
        cap_bits  = '0;
        if (state == WAIT && settled && !an_blank) begin
            if (an_legal) begin
                slot_take = 1'b1;
                if (seg_legal) begin
                    cap_bits = ~an_q;
                end else begin
                    flag_err = 1'b1;
                end
            end else begin
                flag_err = 1'b1;
            end
        end
    end

    // Input register stage. The reset value shows a blank display.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register update from pre-edge values.
        if (!rst) begin
            seg_q <= '0;
            an_q  <= '1;
        end else begin
            seg_q <= seg_hi;
            an_q  <= AN;
        end
    end

`ifdef SEG7_DP_EN
    // Decimal point register. It shares the slot timing with SEG and AN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dp_q <= 1'b0;
        end else begin
            dp_q <= dp_hi;
        end
    end
`endif

    // Stability counter. It restarts on any input change and saturates at SETTLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (in_change) begin
            cnt <= '0;
        end else if (cnt != SETTLE_CNT) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Slot FSM with registered digit, valid, mask, frame_done and err outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= WAIT;
            digits      <= '0;
            digit_valid <= '0;
            mask        <= '0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
`ifdef SEG7_DP_EN
            dp_flags    <= '0;
`endif
        end else begin
            err        <= flag_err;
            frame_done <= mask_full;
            // A capture made while the frame pulse fires counts toward the next frame.
            mask       <= (mask_full ? {N_DIG{1'b0}} : mask) | cap_bits;

            for (int i = 0; i < N_DIG; i++) begin
                if (slot_take && !an_q[i]) begin
                    if (seg_legal) begin
                        digits[4*i +: 4] <= seg_val;
                        digit_valid[i]   <= 1'b1;
`ifdef SEG7_DP_EN
                        dp_flags[i]      <= dp_q;
`endif
                    end else begin
                        digit_valid[i]   <= 1'b0;
                    end
                end
            end

            case (state)
                WAIT: begin
                    // A blank display is never acted on. The counter just keeps running.
                    if (settled && !an_blank) begin
                        if (in_change) begin
                            state <= WAIT;
                        end else if (an_legal) begin
                            state <= STABLE;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                STABLE: begin
                    state <= in_change ? WAIT : HOLD;
                end
                HOLD: begin
                    if (in_change) begin
                        state <= WAIT;
                    end
                end
                default: begin
                    state <= WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder
// Scoreboard bench for seg7_scan_decoder (default build, SETTLE=3, active-low SEG).
// Each stimulus slot is reduced by a slot-level model to the output events it
// must cause (capture, err, frame_done) and the cycle at which each appears.
// A separate monitor pops an event whenever the DUT shows a visible output
// change or pulse, and compares it.
module tb_seg7_scan_decoder;

    localparam int N_DIG  = 4;
    localparam int SETTLE = 3;
    localparam int LAT    = SETTLE + 2;   // cycles from slot start to outputs

    logic                 clk = 1'b0;
    logic                 rst;
    logic [6:0]           SEG;
    logic [N_DIG-1:0]     AN;
    logic [4*N_DIG-1:0]   digits;
    logic [N_DIG-1:0]     digit_valid;
    logic                 frame_done;
    logic                 err;

    seg7_scan_decoder #(
        .N_DIG       (N_DIG),
        .SETTLE      (SETTLE),
        .SEG_ACT_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .SEG         (SEG),
        .AN          (AN),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] digits;
        logic [3:0]  valid;
        logic        err;
        logic        fd;
    } evt_t;

    evt_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic        rst_seen = 1'b0;
    logic [10:0] last_key;

    // Reference glyphs, active-high gfedcba, indexed by hex value.
    logic [6:0]  seg_table [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    // Slot-level model state.
    logic [3:0]       m_val [N_DIG];
    logic [N_DIG-1:0] m_valid;
    logic [N_DIG-1:0] m_mask;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int find_hex(input logic [6:0] s);
        for (int h = 0; h < 16; h++) begin
            if (seg_table[h] == s) return h;
        end
        return -1;
    endfunction

    function automatic logic [15:0] model_digits();
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < N_DIG; i++) r[4*i +: 4] = m_val[i];
        return r;
    endfunction

    // Apply one settled slot to the model and queue the events it must produce.
    task automatic model_slot(input int c, input logic [3:0] an, input logic [6:0] s);
        evt_t        e;
        logic [15:0] old_d;
        logic [3:0]  old_v;
        int          h;
        int          idx;
        logic        e_err;
        old_d = model_digits();
        old_v = m_valid;
        h     = find_hex(s);
        e_err = 1'b0;
        idx   = 0;
        if ($countones(~an) == 1) begin
            for (int i = 0; i < N_DIG; i++) if (!an[i]) idx = i;
            if (h >= 0) begin
                m_val[idx]   = 4'(h);
                m_valid[idx] = 1'b1;
                m_mask[idx]  = 1'b1;
            end else begin
                m_valid[idx] = 1'b0;
                e_err        = 1'b1;
            end
        end else begin
            e_err = 1'b1;
        end
        if (e_err || model_digits() != old_d || m_valid != old_v) begin
            e.cyc = c; e.digits = model_digits(); e.valid = m_valid; e.err = e_err; e.fd = 1'b0;
            exp_q.push_back(e);
        end
        if (m_mask == 4'hF) begin
            e.cyc = c + 1; e.digits = model_digits(); e.valid = m_valid; e.err = 1'b0; e.fd = 1'b1;
            exp_q.push_back(e);
            m_mask = '0;
        end
    endtask

    // Hold one {AN,SEG} value for len cycles. Called #1 after a rising edge.
    task automatic drive_slot(input logic [3:0] an, input logic [6:0] s, input int len);
        int k;
        k   = cyc;
        AN  = an;
        SEG = ~s;
        if (len >= SETTLE + 1 && an != 4'hF) model_slot(k + LAT, an, s);
        last_key = {an, s};
        repeat (len) @(posedge clk);
        #1;
    endtask

    // Hold rst low for n cycles, then check the cleared outputs and release.
    task automatic apply_reset(input int n, input bit rand_in, input logic [3:0] an, input logic [6:0] s);
        rst = 1'b0;
        while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
        for (int i = 0; i < N_DIG; i++) m_val[i] = '0;
        m_valid = '0;
        m_mask  = '0;
        for (int i = 0; i < n; i++) begin
            if (rand_in) begin
                AN  = 4'($urandom);
                SEG = 7'($urandom);
            end else begin
                AN  = an;
                SEG = ~s;
            end
            @(posedge clk);
            #1;
        end
        check("rst_digits", 64'(digits), 64'(0));
        check("rst_digit_valid", 64'(digit_valid), 64'(0));
        check("rst_frame_done", 64'(frame_done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        rst      = 1'b1;
        last_key = {4'hF, 7'h00};
    endtask

    // Monitor: pop and compare whenever the DUT shows an output event.
    initial begin
        evt_t        e;
        logic [15:0] prev_d;
        logic [3:0]  prev_v;
        prev_d = '0;
        prev_v = '0;
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    check("missed_event_cycle", 64'(cyc), 64'(exp_q[0].cyc));
                    void'(exp_q.pop_front());
                end
                if (err || frame_done || digits !== prev_d || digit_valid !== prev_v) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_event: cycle %0d digits=%h valid=%b err=%b frame_done=%b, expected no event",
                                 cyc, digits, digit_valid, err, frame_done);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_cycle", 64'(cyc), 64'(e.cyc));
                        check("event_digits", 64'(digits), 64'(e.digits));
                        check("event_valid", 64'(digit_valid), 64'(e.valid));
                        check("event_err", 64'(err), 64'(e.err));
                        check("event_frame_done", 64'(frame_done), 64'(e.fd));
                    end
                end
            end
            prev_d = digits;
            prev_v = digit_valid;
        end
    end

    // Watchdog: the run must never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        AN       = 4'hF;
        SEG      = 7'h7F;
        last_key = {4'hF, 7'h00};
        for (int i = 0; i < N_DIG; i++) m_val[i] = '0;
        m_valid = '0;
        m_mask  = '0;
        @(posedge clk);
        #1;

        // Reset hold with random pins.
        apply_reset(2, 1'b1, 4'hF, 7'h00);

        // Full frame 1,2,3,4.
        drive_slot(4'b1110, 7'b0000110, 8);
        drive_slot(4'b1101, 7'b1011011, 8);
        drive_slot(4'b1011, 7'b1001111, 8);
        drive_slot(4'b0111, 7'b1100110, 8);
        check("frame_digits", 64'(digits), 64'(16'h4321));
        check("frame_valid", 64'(digit_valid), 64'(4'hF));

        // Glitch rejection: 5 for 2 cycles, an 8 for 1 cycle, then 5 for 4 cycles.
        drive_slot(4'b1110, seg_table[5], 2);
        drive_slot(4'b1110, seg_table[8], 1);
        drive_slot(4'b1110, seg_table[5], 4);

        // Illegal segments on digit 0.
        drive_slot(4'b1110, 7'b1010101, 6);
        check("illegal_seg_valid0", 64'(digit_valid[0]), 64'(0));
        check("illegal_seg_digit0", 64'(digits[3:0]), 64'(5));

        // Illegal anode code, then a blank display.
        drive_slot(4'b1100, 7'b0000110, 6);
        drive_slot(4'b1111, 7'b0000110, 10);

        // Reset mid-frame. The slot held through reset must count SETTLE again.
        drive_slot(4'b1110, seg_table[7], 6);
        drive_slot(4'b1101, seg_table[8], 6);
        drive_slot(4'b1011, seg_table[9], 2);
        apply_reset(1, 1'b0, 4'b1011, seg_table[9]);
        drive_slot(4'b1011, seg_table[9], 8);
        drive_slot(4'b1110, seg_table[10], 8);
        drive_slot(4'b1101, seg_table[11], 8);
        drive_slot(4'b0111, seg_table[12], 8);
        check("post_reset_digits", 64'(digits), 64'(16'hC9BA));

        // Randomized slots.
        for (int n = 0; n < 40; n++) begin
            logic [3:0] an;
            logic [6:0] s;
            int         pick;
            int         len;
            int         hx;
            do begin
                pick = $urandom_range(0, 9);
                if (pick < 7) begin
                    an = ~(4'b0001 << $urandom_range(0, 3));
                end else if (pick == 7) begin
                    an = 4'hF;
                end else begin
                    do an = 4'($urandom); while ($countones(~an) < 2);
                end
                if ($urandom_range(0, 9) < 7) begin
                    hx = $urandom_range(0, 15);
                    s  = seg_table[hx];
                end else begin
                    s = 7'($urandom);
                end
            end while ({an, s} == last_key);
            len = $urandom_range(1, 10);
            drive_slot(an, s, len);
        end

        // Blank tail to flush the last events, then drain the scoreboard.
        drive_slot(4'hF, (last_key == {4'hF, 7'h00}) ? 7'h01 : 7'h00, 12);
        for (int w = 0; w < 40 && exp_q.size() > 0; w++) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
